// File: rtl/signext_pipe_if.sv
// signext_pipe_if
//   Handshake bundle for the signext_pipe immediate generator.
//   Ports / signals:
//     in_valid, in_instr[31:0]  producer -> pipe, instruction offer
//     in_ready                  pipe -> producer, an entry slot is free
//     out_valid                 pipe -> consumer, head entry present
//     out_ready                 consumer -> pipe, head entry taken this cycle
//     out_imm[DATA_W-1:0]       extended immediate of the head entry
//     out_fmt[2:0]              head format: 0 D, 1 CB, 2 B, 3 I, 4 IW, 7 illegal
//     out_illegal               head entry had no decodable opcode
//   Modports: master = environment (decode stage / ALU mux), slave = signext_pipe.
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both high; valid must not depend combinationally on ready.
interface signext_pipe_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [2:0]        out_fmt;
    logic              out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/signext_pipe.sv
// signext_pipe
//   Buffered LEGv8 immediate generator. Each accepted instruction word is
//   decoded (CB, D, I, B, IW or illegal), its immediate is extended to DATA_W,
//   and the result is queued in a DEPTH-entry FIFO for the ALU-operand mux.
//   Ports:
//     clk        rising-edge clock
//     reset_n    asynchronous active-low reset
//     flush      synchronous FIFO clear (e.g. branch mispredict)
//     bus        signext_pipe_if.slave: in_valid/in_ready/in_instr,
//                out_valid/out_ready/out_imm/out_fmt/out_illegal
//     ill_count  saturating count of accepted illegal instructions
//   Optional feature macro: SIGNEXT_PIPE_SCALE_EN -- when defined, B and CB
//   immediates are shifted left by 2 (byte offset) before sign extension.
module signext_pipe #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    signext_pipe_if.slave    bus,
    output logic [CNT_W-1:0] ill_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] FMT_D   = 3'd0;
    localparam logic [2:0] FMT_CB  = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_I   = 3'd3;
    localparam logic [2:0] FMT_IW  = 3'd4;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic [2:0]        fmt;
        logic              ill;
    } entry_t;

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [AW:0] cnt_next;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        push;
    logic        pop;

    // ---------------- decode ----------------
    logic [31:0] instr;
    logic [63:0] wide;
    logic [2:0]  dec_fmt;
    logic        dec_ill;
    logic [1:0]  hw;

    assign instr = bus.in_instr;
    assign hw    = instr[22:21];

    // Register numbers are not part of the immediate.
    logic unused_regs;
    assign unused_regs = ^instr[4:0];

    // Everything is built 64 bits wide, then truncated to DATA_W; the
    // narrowest legal DATA_W (32) still holds every sign bit of interest.
    always_comb begin
        wide    = '0;
        dec_fmt = FMT_ILL;
        dec_ill = 1'b1;
        if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101 ||
            instr[31:24] == 8'b01010100) begin
            dec_fmt = FMT_CB;
            dec_ill = 1'b0;
`ifdef SIGNEXT_PIPE_SCALE_EN
            wide    = {{43{instr[23]}}, instr[23:5], 2'b00};
`else
            wide    = {{45{instr[23]}}, instr[23:5]};
`endif
        end else if (instr[31:21] == 11'b11111000010 ||
                     instr[31:21] == 11'b11111000000) begin
            dec_fmt = FMT_D;
            dec_ill = 1'b0;
            wide    = {{55{instr[20]}}, instr[20:12]};
        end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100 ||
                     instr[31:22] == 10'b1011000100 || instr[31:22] == 10'b1111000100) begin
            dec_fmt = FMT_I;
            dec_ill = 1'b0;
            wide    = {52'd0, instr[21:10]};
        end else if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
            dec_fmt = FMT_B;
            dec_ill = 1'b0;
`ifdef SIGNEXT_PIPE_SCALE_EN
            wide    = {{36{instr[25]}}, instr[25:0], 2'b00};
`else
            wide    = {{38{instr[25]}}, instr[25:0]};
`endif
        end else if (instr[31:23] == 9'b110100101) begin
            // A halfword placed beyond DATA_W cannot be represented.
            if ((int'(hw) * 16 + 16) <= DATA_W) begin
                dec_fmt = FMT_IW;
                dec_ill = 1'b0;
                wide    = {48'd0, instr[20:5]} << {hw, 4'b0000};
            end
        end
    end

    // ---------------- FIFO ----------------
    // Acceptance uses the registered in_ready, so a full FIFO refuses a
    // push even when the head is popped in the same cycle.
    assign push     = bus.in_valid && in_ready_q && !flush;
    assign pop      = out_valid_q && bus.out_ready;
    assign count    = wr_ptr - rd_ptr;
    assign cnt_next = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ill_count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr[AW-1:0]] <= '{imm: wide[DATA_W-1:0], fmt: dec_fmt, ill: dec_ill};
                    wr_ptr              <= wr_ptr + (AW+1)'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
                in_ready_q  <= (cnt_next != FULL_CNT);
                out_valid_q <= (cnt_next != '0);
            end
            // push already excludes the flush cycle, so discarded words never count.
            if (push && dec_ill && ill_count != '1) begin
                ill_count <= ill_count + CNT_W'(1);
            end
        end
    end

    entry_t head;
    assign head = mem[rd_ptr[AW-1:0]];

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = head.imm;
    assign bus.out_fmt     = head.fmt;
    assign bus.out_illegal = head.ill;
endmodule
